// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter family: parity and FSM state
// enums, the 16x oversampling constant and the baud divisor table.
// The divisors assume a 50 MHz system clock:
//   divisor = round(50e6 / (16 * baud)) cycles per oversample tick.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  // Widest divisor is 10417 (300 baud), which needs 14 bits.
  localparam int DIV_W      = 14;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Cycles per oversample tick for each 3-bit rate code.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    logic [DIV_W-1:0] d;
    d = 14'd27;
    case (sel)
      3'd0: d = 14'd10417;  //    300 baud
      3'd1: d = 14'd2604;   //   1200 baud
      3'd2: d = 14'd651;    //   4800 baud
      3'd3: d = 14'd326;    //   9600 baud
      3'd4: d = 14'd163;    //  19200 baud
      3'd5: d = 14'd81;     //  38400 baud
      3'd6: d = 14'd54;     //  57600 baud
      3'd7: d = 14'd27;     // 115200 baud
      default: d = 14'd27;
    endcase
    return d;
  endfunction

  // Parity bit for up to 9 data bits; narrower words are zero-padded, which
  // leaves the XOR unchanged. Even mode makes data+parity carry an even
  // number of ones, odd mode an odd number.
  function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) p = ~p;
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Divisor counter producing a one-cycle tick every `div` clock cycles.
// A synchronous restart zeroes the count so the first tick arrives exactly
// `div` cycles after the restart edge.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   restart  in   synchronous restart of the count
//   div      in   cycles per tick (>= 1)
//   tick     out  high for one cycle when the count reaches div-1
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == div - ONE);

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter. Host writes land in a FIFO_DEPTH-entry circular
// buffer; the frame FSM pops words and serialises them onto txd as
//   start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop(1).
// Every bit lasts OVERSAMPLE ticks of the divisor latched at frame start.
// Ports:
//   clk          in   system clock (50 MHz)
//   reset        in   asynchronous, active-high
//   tx_data      in   word to enqueue
//   baud_select  in   rate code, sampled at each frame start
//   tx_wr        in   write strobe, rising edge enqueues tx_data
//   tx_en        in   allows the FSM to pop and start frames
//   txd          out  serial line, idle high, registered
//   tx_busy      out  FSM not in IDLE
//   tx_full      out  FIFO full
//   tx_empty     out  FIFO empty
//   tx_level     out  entries held
//   tx_overflow  out  one-cycle pulse when a write edge hits a full FIFO
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      DATA_W     = 8,
  parameter int      FIFO_DEPTH = 4,
  parameter parity_e PARITY     = PAR_EVEN,
  parameter int      STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [2:0]                  baud_select,
  input  logic                        tx_wr,
  input  logic                        tx_en,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        tx_overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BIT_W = 4;  // counts up to 9 data bits or 2 stop bits

  localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVERSAMPLE-1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W-1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS-1);

  // -------------------------------------------------------------------------
  // Write port: strobe and data are registered together, the edge is found
  // between the last two samples.
  // -------------------------------------------------------------------------
  logic              tx_wr_q, tx_wr_q2;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_edge;

  assign wr_edge = tx_wr_q & ~tx_wr_q2;

  // -------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty are distinct
  // when the index bits match.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Full is the registered state: a pop in the same cycle does not make room.
  assign push       = wr_edge & ~fifo_full;
  assign head       = mem[rd_ptr[AW-1:0]];

  assign tx_empty = fifo_empty;
  assign tx_full  = fifo_full;
  assign tx_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q     <= 1'b0;
      tx_wr_q2    <= 1'b0;
      wr_data_q   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      tx_wr_q     <= tx_wr;
      tx_wr_q2    <= tx_wr_q;
      wr_data_q   <= tx_data;
      tx_overflow <= wr_edge & fifo_full;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; pointer reset alone empties the
  // FIFO, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data_q;
  end

  // -------------------------------------------------------------------------
  // Oversample tick generator, restarted at each frame start so every bit is
  // exactly OVERSAMPLE * div cycles.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             restart;
  logic             tick;

  uart_baud_tick #(
    .CNT_W (DIV_W)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  tx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              can_start, start_frame, bit_end;

  assign can_start = tx_en & ~fifo_empty;
  assign bit_end   = tick && (tick_cnt_q == TICK_MAX);

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    div_d       = div_q;
    txd_d       = txd_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    restart     = 1'b0;

    // The tick count wraps from OVERSAMPLE-1 to 0 at each bit boundary.
    if (tick) tick_cnt_d = tick_cnt_q + TICK_ONE;

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (can_start) start_frame = 1'b1;
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          txd_d     = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY == PAR_NONE) begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end else begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            shreg_d   = shreg_q >> 1;
            txd_d     = shreg_d[0];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          txd_d     = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) begin
            // Chain straight into the next frame when possible, so there is
            // no idle cycle between back-to-back frames.
            if (can_start) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame start: pop the head word, latch it with its parity and the
    // currently selected divisor, and drive the start bit on the same edge.
    if (start_frame) begin
      pop        = 1'b1;
      restart    = 1'b1;
      state_d    = ST_START;
      txd_d      = 1'b0;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shreg_d    = head;
      par_d      = parity_bit(9'(head), PARITY);
      div_d      = baud_div(baud_select);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      div_q      <= baud_div(3'd7);
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      div_q      <= div_d;
      txd_q      <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Three transmitter configurations share clock and reset:
//   [0] DATA_W=8, even parity, 1 stop
//   [1] DATA_W=8, odd parity,  1 stop
//   [2] DATA_W=7, no parity,   2 stops
// Stimulus pushes hand-written frame bit strings (transmission order) into a
// queue; a monitor process watches the selected txd, pops a frame on each
// start bit and checks the first and last cycle of every bit, then that the
// line either idles or starts the next queued frame with no gap.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [8:0]      tx_data;
  logic [2:0]      baud_select;
  logic [NI-1:0]   tx_wr;
  logic            tx_en;
  logic [NI-1:0]   txd_v, busy_v, full_v, empty_v, ovf_v;
  logic [2:0]      level_v [NI];

  int sel = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #10 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_dut_even (
    .clk (clk), .reset (reset), .tx_data (tx_data[7:0]), .baud_select (baud_select),
    .tx_wr (tx_wr[0]), .tx_en (tx_en), .txd (txd_v[0]), .tx_busy (busy_v[0]),
    .tx_full (full_v[0]), .tx_empty (empty_v[0]), .tx_level (level_v[0]),
    .tx_overflow (ovf_v[0])
  );

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY(PAR_ODD), .STOP_BITS(1)) u_dut_odd (
    .clk (clk), .reset (reset), .tx_data (tx_data[7:0]), .baud_select (baud_select),
    .tx_wr (tx_wr[1]), .tx_en (tx_en), .txd (txd_v[1]), .tx_busy (busy_v[1]),
    .tx_full (full_v[1]), .tx_empty (empty_v[1]), .tx_level (level_v[1]),
    .tx_overflow (ovf_v[1])
  );

  uart_tx_fifo #(.DATA_W(7), .FIFO_DEPTH(4), .PARITY(PAR_NONE), .STOP_BITS(2)) u_dut_7n2 (
    .clk (clk), .reset (reset), .tx_data (tx_data[6:0]), .baud_select (baud_select),
    .tx_wr (tx_wr[2]), .tx_en (tx_en), .txd (txd_v[2]), .tx_busy (busy_v[2]),
    .tx_full (full_v[2]), .tx_empty (empty_v[2]), .tx_level (level_v[2]),
    .tx_overflow (ovf_v[2])
  );

  // -------------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [15:0] bits;   // bits[0] is transmitted first
    int          n;
    int          bitc;   // cycles per bit
  } frame_t;

  frame_t exp_q[$];

  task automatic push_frame(input string s, input int bitc);
    frame_t f;
    f.bits = '0;
    f.n    = s.len();
    f.bitc = bitc;
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s[i] == 8'h31);
    exp_q.push_back(f);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle strobe then two idle cycles; on return the level has updated.
  task automatic write_word(input int idx, input logic [8:0] d);
    tx_data    = d;
    tx_wr[idx] = 1'b1;
    cyc(1);
    tx_wr[idx] = 1'b0;
    cyc(2);
  endtask

  task automatic wait_busy(input string name, input int limit);
    int n;
    n = 0;
    while (busy_v[sel] !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, busy_v[sel], 1);
  endtask

  // Called on a negedge where busy is high; returns the number of busy cycles.
  task automatic measure_busy(input int limit, output int n);
    n = 0;
    while (busy_v[sel] === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor: decode frames on the selected line against the expected queue
  // -------------------------------------------------------------------------
  initial begin : monitor
    frame_t f;
    bit     ab;
    bit     more;
    int     guard;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || txd_v[sel] !== 1'b0) continue;
      ab   = 1'b0;
      more = 1'b1;
      while (more && !ab) begin
        check("mon_frame_queued", exp_q.size() != 0, 1);
        if (exp_q.size() == 0) begin
          guard = 0;
          while (busy_v[sel] === 1'b1 && !ab && guard < 20000) begin
            mon_wait(1, ab);
            guard++;
          end
          more = 1'b0;
        end else begin
          f = exp_q.pop_front();
          for (int k = 0; k < f.n && !ab; k++) begin
            check($sformatf("mon_bit%0d_first", k), txd_v[sel], f.bits[k]);
            mon_wait(f.bitc - 1, ab);
            if (!ab) check($sformatf("mon_bit%0d_last", k), txd_v[sel], f.bits[k]);
            mon_wait(1, ab);
          end
          if (!ab) begin
            if (exp_q.size() != 0) begin
              check("mon_gapless_next_start", txd_v[sel], 0);
            end else begin
              check("mon_line_idle", txd_v[sel], 1);
              check("mon_busy_clear", busy_v[sel], 0);
              more = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(20 * 95000);
    $display("FAIL watchdog: cycle budget exhausted at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin : stimulus
    int n;
    int ovf_cnt;
    logic [2:0] lvl_mid;

    reset       = 1'b1;
    tx_data     = '0;
    baud_select = 3'd7;
    tx_wr       = '0;
    tx_en       = 1'b0;
    cyc(3);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_txd", i), txd_v[i], 1);
      check($sformatf("rst%0d_busy", i), busy_v[i], 0);
      check($sformatf("rst%0d_empty", i), empty_v[i], 1);
      check($sformatf("rst%0d_full", i), full_v[i], 0);
      check($sformatf("rst%0d_level", i), level_v[i], 0);
      check($sformatf("rst%0d_overflow", i), ovf_v[i], 0);
    end
    reset = 1'b0;
    cyc(3);

    // ---- 1: single 0xDD, even parity, 115200 baud, latency and length ----
    sel   = 0;
    tx_en = 1'b1;
    push_frame("01011101101", 432);
    tx_data  = 9'h0DD;
    tx_wr[0] = 1'b1;
    cyc(1);                       // after edge N
    check("lat_n_txd", txd_v[0], 1);
    cyc(1);                       // after edge N+1: word stored
    check("lat_n1_txd", txd_v[0], 1);
    check("lat_n1_level", level_v[0], 1);
    cyc(1);                       // after edge N+2: start bit, word popped
    tx_wr[0] = 1'b0;
    check("lat_n2_txd", txd_v[0], 0);
    check("lat_n2_busy", busy_v[0], 1);
    check("lat_n2_level", level_v[0], 0);
    measure_busy(6000, n);
    check("even_frame_cycles", n, 4752);
    cyc(5);

    // ---- 2: fill with tx_en low, overflow on the fifth edge, then drain ----
    tx_en = 1'b0;
    write_word(0, 9'h001);
    write_word(0, 9'h080);
    write_word(0, 9'h0FF);
    write_word(0, 9'h000);
    check("fill_level", level_v[0], 4);
    check("fill_full", full_v[0], 1);
    check("fill_empty", empty_v[0], 0);
    tx_data  = 9'h05A;
    tx_wr[0] = 1'b1;
    cyc(1);
    tx_wr[0] = 1'b0;
    ovf_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      if (ovf_v[0] === 1'b1) ovf_cnt++;
      cyc(1);
    end
    check("overflow_pulse_cycles", ovf_cnt, 1);
    check("overflow_level", level_v[0], 4);
    push_frame("01000000011", 432);   // 0x01, parity 1
    push_frame("00000000111", 432);   // 0x80, parity 1
    push_frame("01111111101", 432);   // 0xFF, parity 0
    push_frame("00000000001", 432);   // 0x00, parity 0
    tx_en = 1'b1;
    wait_busy("drain_busy_rise", 10);
    measure_busy(25000, n);
    check("drain_busy_cycles", n, 19008);
    check("drain_empty", empty_v[0], 1);
    check("drain_level", level_v[0], 0);
    cyc(5);

    // ---- 3: tx_en dropped during data bit 3 ----
    tx_en = 1'b0;
    write_word(0, 9'h0DD);
    write_word(0, 9'h001);
    check("endrop_pre_level", level_v[0], 2);
    push_frame("01011101101", 432);
    tx_en = 1'b1;
    wait_busy("endrop_busy_rise", 10);
    cyc(4 * 432 + 200);
    tx_en = 1'b0;
    n = 0;
    while (busy_v[0] === 1'b1 && n < 6000) begin
      cyc(1);
      n++;
    end
    check("endrop_frame_done", busy_v[0], 0);
    check("endrop_level_kept", level_v[0], 1);
    cyc(1000);
    check("endrop_txd_idle", txd_v[0], 1);
    check("endrop_still_idle", busy_v[0], 0);
    check("endrop_level_later", level_v[0], 1);

    // ---- 4: reset pulsed during a data bit ----
    push_frame("01000000011", 432);   // stored 0x01 goes out next
    tx_en = 1'b1;
    wait_busy("rst_busy_rise", 10);
    write_word(0, 9'h033);
    check("rst_pre_level", level_v[0], 1);
    cyc(3 * 432);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_txd", txd_v[0], 1);
    check("rst_async_level", level_v[0], 0);
    check("rst_async_busy", busy_v[0], 0);
    cyc(3);
    reset = 1'b0;
    exp_q.delete();
    cyc(1000);
    check("rst_after_txd", txd_v[0], 1);
    check("rst_after_busy", busy_v[0], 0);
    check("rst_after_empty", empty_v[0], 1);

    // ---- 5: odd parity, two frames back to back ----
    sel   = 1;
    tx_en = 1'b0;
    write_word(1, 9'h0DD);
    write_word(1, 9'h001);
    check("odd_level_two", level_v[1], 2);
    push_frame("01011101111", 432);   // 0xDD, odd parity 1
    push_frame("01000000001", 432);   // 0x01, odd parity 0
    tx_en = 1'b1;
    wait_busy("odd_busy_rise", 10);
    check("odd_level_one", level_v[1], 1);
    n       = 0;
    lvl_mid = 3'h7;
    while (busy_v[1] === 1'b1 && n < 20000) begin
      if (n == 4760) lvl_mid = level_v[1];
      n++;
      cyc(1);
    end
    check("odd_busy_cycles", n, 9504);
    check("odd_level_zero", lvl_mid, 0);
    cyc(5);

    // ---- 6: 7 data bits, no parity, 2 stop bits, 57600 baud ----
    sel         = 2;
    baud_select = 3'd6;
    push_frame("0101010111", 864);
    write_word(2, 9'h055);
    check("7n2_busy", busy_v[2], 1);
    measure_busy(12000, n);
    check("7n2_frame_cycles", n, 8640);
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
